// File: rtl/grex_emu_pkg.sv
// ----------------------------------------------------------------------------
// grex_emu_pkg
// Shared types and constants for the GREX temperature front-end emulator.
//   emu_state_t   : responder state (OFF, WARMUP, HOLD, INTEG, DONE)
//   DEF_*         : default WARMUP_CYCLES / NOISE_SEED values
//   LFSR_TAPS     : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   base_target   : count_target with 0 mapped to 1
//   noisy_target  : +/-1 jitter selected by two LFSR bits, clamped to 1..255
// ----------------------------------------------------------------------------
package grex_emu_pkg;

   typedef enum logic [2:0] {OFF, WARMUP, HOLD, INTEG, DONE} emu_state_t;

   localparam int unsigned DEF_WARMUP_CYCLES = 8;
   localparam logic [7:0]  DEF_NOISE_SEED    = 8'hA5;
   localparam logic [7:0]  LFSR_TAPS         = 8'hB8;

   function automatic logic [7:0] base_target(input logic [7:0] ct);
      return (ct == 8'd0) ? 8'd1 : ct;
   endfunction

   function automatic logic [7:0] noisy_target(input logic [7:0] base, input logic [1:0] sel);
      logic [7:0] res;
      res = base;
      case (sel)
         2'b00:   res = (base <= 8'd1) ? 8'd1 : base - 8'd1;
         2'b11:   res = (base == 8'hFF) ? 8'hFF : base + 8'd1;
         default: res = base;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/grex_sensor_emu_if.sv
// ----------------------------------------------------------------------------
// grex_sensor_emu_if
// Controller <-> emulator handshake bundle.
//   master (controller): drives PWRUP_1V8, RESET_1V8, count_target, pulse_div
//   slave  (emulator)  : drives PULSE_1V8, DO_1V8, busy, conversions
// ----------------------------------------------------------------------------
interface grex_sensor_emu_if;

   logic       PWRUP_1V8;
   logic       RESET_1V8;
   logic [7:0] count_target;
   logic [3:0] pulse_div;
   logic       PULSE_1V8;
   logic       DO_1V8;
   logic       busy;
   logic [7:0] conversions;

   modport master (
      output PWRUP_1V8, RESET_1V8, count_target, pulse_div,
      input  PULSE_1V8, DO_1V8, busy, conversions
   );

   modport slave (
      input  PWRUP_1V8, RESET_1V8, count_target, pulse_div,
      output PULSE_1V8, DO_1V8, busy, conversions
   );

endinterface

// File: rtl/grex_lfsr8.sv
// ----------------------------------------------------------------------------
// grex_lfsr8
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), shifts left, advances on step.
//   clk, reset_n : clock, async active-low reset (loads seed)
//   step         : advance one position this edge
//   seed         : reset value (must be non-zero)
//   q            : current register value
// ----------------------------------------------------------------------------
module grex_lfsr8
   import grex_emu_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       step,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   logic [7:0] r_q;
   logic       w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= seed;
      end else if (step) begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/grex_sensor_emu.sv
// ----------------------------------------------------------------------------
// grex_sensor_emu
// Digital stand-in for the GREX analog temperature front-end (responder side
// of the PWRUP/RESET -> PULSE/DO handshake).
//   clk      : clock, all logic on posedge
//   reset_n  : async active-low reset
//   io_emu   : grex_sensor_emu_if.slave
//              in : PWRUP_1V8, RESET_1V8, count_target[7:0], pulse_div[3:0]
//              out: PULSE_1V8, DO_1V8, busy, conversions[7:0] (all registered)
// Parameters : WARMUP_CYCLES, NOISE_SEED
// Build macro: GREX_EMU_NOISE_EN adds LFSR jitter of +/-1 to the target.
// ----------------------------------------------------------------------------
module grex_sensor_emu
   import grex_emu_pkg::*;
#(
   parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
   parameter logic [7:0]  NOISE_SEED    = DEF_NOISE_SEED
) (
   input  logic               clk,
   input  logic               reset_n,
   grex_sensor_emu_if.slave   io_emu
);

   // Last timer value in WARMUP; a zero-length warmup still spends one cycle.
   localparam logic [15:0] WARM_LAST = (WARMUP_CYCLES == 0) ? 16'd0 : 16'(WARMUP_CYCLES - 1);

   emu_state_t r_state, w_state_nxt;
   logic [15:0] r_timer, w_timer_nxt;
   logic [7:0]  r_k, w_k_nxt;
   logic [7:0]  r_tgt, w_tgt_nxt;
   logic [7:0]  r_conv, w_conv_nxt;
   logic        r_pulse, w_pulse_nxt;
   logic        r_do, w_do_nxt;
   logic        r_busy, w_busy_nxt;
   logic        w_integ_entry;
   logic [7:0]  w_entry_tgt;
   logic [7:0]  w_div;
   logic [7:0]  w_rem;

   // Live pulse_div: phase is recomputed from k every cycle.
   assign w_div = {4'd0, io_emu.pulse_div} + 8'd1;
   assign w_rem = r_k % w_div;

`ifdef GREX_EMU_NOISE_EN
   logic [7:0] w_lfsr_q;
   logic       w_unused_lfsr;

   grex_lfsr8 u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .step    (w_integ_entry),
      .seed    (NOISE_SEED),
      .q       (w_lfsr_q)
   );

   assign w_unused_lfsr = ^w_lfsr_q[7:2];
   assign w_entry_tgt   = noisy_target(base_target(io_emu.count_target), w_lfsr_q[1:0]);
`else
   logic w_unused_seed;
   assign w_unused_seed = ^NOISE_SEED;
   assign w_entry_tgt   = base_target(io_emu.count_target);
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= OFF;
         r_timer <= '0;
         r_k     <= '0;
         r_tgt   <= 8'd1;
         r_conv  <= '0;
         r_pulse <= 1'b0;
         r_do    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_k     <= w_k_nxt;
         r_tgt   <= w_tgt_nxt;
         r_conv  <= w_conv_nxt;
         r_pulse <= w_pulse_nxt;
         r_do    <= w_do_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_k_nxt       = r_k;
      w_tgt_nxt     = r_tgt;
      w_conv_nxt    = r_conv;
      w_pulse_nxt   = 1'b0;
      w_do_nxt      = 1'b0;
      w_integ_entry = 1'b0;

      if (!io_emu.PWRUP_1V8) begin
         // Power loss wins from every state; the conversion count survives.
         w_state_nxt = OFF;
         w_timer_nxt = '0;
         w_k_nxt     = '0;
      end else begin
         unique case (r_state)
            OFF: begin
               w_state_nxt = WARMUP;
               w_timer_nxt = '0;
            end
            WARMUP: begin
               if (r_timer >= WARM_LAST) begin
                  if (io_emu.RESET_1V8) begin
                     w_state_nxt = HOLD;
                  end else begin
                     w_integ_entry = 1'b1;
                  end
               end else begin
                  w_timer_nxt = r_timer + 16'd1;
               end
            end
            HOLD: begin
               if (!io_emu.RESET_1V8) begin
                  w_integ_entry = 1'b1;
               end
            end
            INTEG: begin
               // Pulse reports the integration cycle that just ended.
               w_pulse_nxt = (w_rem == {4'd0, io_emu.pulse_div});
               if (io_emu.RESET_1V8) begin
                  w_state_nxt = HOLD;
               end else if (r_k + 8'd1 == r_tgt) begin
                  w_state_nxt = DONE;
                  w_k_nxt     = r_tgt;
                  w_do_nxt    = 1'b1;
               end else begin
                  w_k_nxt = r_k + 8'd1;
               end
            end
            DONE: begin
               if (io_emu.RESET_1V8) begin
                  w_state_nxt = HOLD;
                  w_conv_nxt  = r_conv + 8'd1;
               end else begin
                  w_do_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = OFF;
            end
         endcase
      end

      if (w_integ_entry) begin
         w_state_nxt = INTEG;
         w_k_nxt     = '0;
         w_tgt_nxt   = w_entry_tgt;
      end

      w_busy_nxt = (w_state_nxt == WARMUP) || (w_state_nxt == INTEG);
   end

   assign io_emu.PULSE_1V8   = r_pulse;
   assign io_emu.DO_1V8      = r_do;
   assign io_emu.busy        = r_busy;
   assign io_emu.conversions = r_conv;

endmodule

// File: tb/tb_grex_sensor_emu.sv
// ----------------------------------------------------------------------------
// tb_grex_sensor_emu
// Self-checking bench for grex_sensor_emu: vector table, hand-written
// abort/latch/wrap sequences and randomized conversions against a
// conversion-level reference model.
// ----------------------------------------------------------------------------
module tb_grex_sensor_emu;

   localparam int          WARM = 8;
   localparam logic [7:0]  SEED = 8'hA5;

   typedef struct {
      logic [7:0] ct;
      logic [3:0] pd;
      int         exp_cyc;
      int         exp_pulses;
   } vec_t;

   logic clk;
   logic reset_n;

   grex_sensor_emu_if emu_if ();

   grex_sensor_emu #(
      .WARMUP_CYCLES (WARM),
      .NOISE_SEED    (SEED)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .io_emu  (emu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks;
   int         n_errors;
   logic [7:0] exp_conv;
   logic [7:0] m_lfsr;
   vec_t       vecs [10];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Conversion-level model: target chosen at each integration entry.
   task automatic model_entry(input logic [7:0] ct, output int tgt);
      int base;
      base = (ct == 8'd0) ? 1 : int'(ct);
      tgt  = base;
`ifdef GREX_EMU_NOISE_EN
      if (m_lfsr[1:0] == 2'b00) tgt = base - 1;
      if (m_lfsr[1:0] == 2'b11) tgt = base + 1;
      if (tgt < 1)   tgt = 1;
      if (tgt > 255) tgt = 255;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
   endtask

   // Starts from HOLD with RESET_1V8=1, ends back in HOLD.
   task automatic run_conversion(input logic [7:0] ct, input logic [3:0] pd,
                                 input int exp_cyc, input int exp_pulses,
                                 input int hold_len, input int done_len,
                                 input int chg_at, input logic [7:0] chg_ct,
                                 output int got_cyc);
      int cyc, pulses, mtgt;
      emu_if.count_target = ct;
      emu_if.pulse_div    = pd;
      for (int i = 0; i < hold_len; i++) begin
         tick();
         check("hold_do", int'(emu_if.DO_1V8), 0);
         check("hold_busy", int'(emu_if.busy), 0);
      end
      model_entry(ct, mtgt);
`ifdef GREX_EMU_NOISE_EN
      exp_cyc    = mtgt;
      exp_pulses = mtgt / (int'(pd) + 1);
`endif
      emu_if.RESET_1V8 = 1'b0;
      tick();
      check("integ_busy", int'(emu_if.busy), 1);
      check("integ_do0", int'(emu_if.DO_1V8), 0);
      cyc    = 0;
      pulses = 0;
      while (cyc < 300) begin
         tick();
         cyc++;
         if (emu_if.PULSE_1V8) pulses++;
         if (emu_if.DO_1V8) break;
         if (cyc == chg_at) emu_if.count_target = chg_ct;
      end
      got_cyc = cyc;
      check("do_latency", cyc, exp_cyc);
      check("pulse_count", pulses, exp_pulses);
      check("done_conv", int'(emu_if.conversions), int'(exp_conv));
      for (int i = 0; i < done_len; i++) begin
         tick();
         check("done_do_held", int'(emu_if.DO_1V8), 1);
         check("done_pulse0", int'(emu_if.PULSE_1V8), 0);
         check("done_busy0", int'(emu_if.busy), 0);
      end
      emu_if.RESET_1V8 = 1'b1;
      tick();
      exp_conv = exp_conv + 8'd1;
      check("do_drop", int'(emu_if.DO_1V8), 0);
      check("conv_inc", int'(emu_if.conversions), int'(exp_conv));
   endtask

   task automatic power_up();
      emu_if.PWRUP_1V8 = 1'b1;
      emu_if.RESET_1V8 = 1'b1;
      repeat (WARM + 3) tick();
      check("powerup_hold_busy", int'(emu_if.busy), 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n  = 1'b1;
      exp_conv = 8'd0;
      m_lfsr   = SEED;
      power_up();
      check("reset_conv", int'(emu_if.conversions), 0);
   endtask

   initial begin
      int warm, got, t, do_seen;
      logic [7:0] rct;
      logic [3:0] rpd;
      int rexp;

      n_checks = 0;
      n_errors = 0;
      exp_conv = 8'd0;
      m_lfsr   = SEED;

      vecs[0] = '{ct: 8'd65,  pd: 4'd3,  exp_cyc: 65,  exp_pulses: 16};
      vecs[1] = '{ct: 8'd16,  pd: 4'd3,  exp_cyc: 16,  exp_pulses: 4};
      vecs[2] = '{ct: 8'd5,   pd: 4'd0,  exp_cyc: 5,   exp_pulses: 5};
      vecs[3] = '{ct: 8'd0,   pd: 4'd0,  exp_cyc: 1,   exp_pulses: 1};
      vecs[4] = '{ct: 8'd1,   pd: 4'd5,  exp_cyc: 1,   exp_pulses: 0};
      vecs[5] = '{ct: 8'd255, pd: 4'd15, exp_cyc: 255, exp_pulses: 15};
      vecs[6] = '{ct: 8'd7,   pd: 4'd6,  exp_cyc: 7,   exp_pulses: 1};
      vecs[7] = '{ct: 8'd30,  pd: 4'd1,  exp_cyc: 30,  exp_pulses: 15};
      vecs[8] = '{ct: 8'd2,   pd: 4'd1,  exp_cyc: 2,   exp_pulses: 1};
      vecs[9] = '{ct: 8'd3,   pd: 4'd15, exp_cyc: 3,   exp_pulses: 0};

      reset_n             = 1'b0;
      emu_if.PWRUP_1V8    = 1'b1;
      emu_if.RESET_1V8    = 1'b1;
      emu_if.count_target = 8'd0;
      emu_if.pulse_div    = 4'd0;
      repeat (3) tick();
      check("rst_pulse", int'(emu_if.PULSE_1V8), 0);
      check("rst_do", int'(emu_if.DO_1V8), 0);
      check("rst_busy", int'(emu_if.busy), 0);
      check("rst_conv", int'(emu_if.conversions), 0);

      reset_n = 1'b1;
      warm    = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (emu_if.busy) warm++;
         else if (warm > 0) break;
      end
      check("warmup_len", warm, WARM);
      repeat (18) tick();

      // Vector table
      foreach (vecs[i]) begin
         run_conversion(vecs[i].ct, vecs[i].pd, vecs[i].exp_cyc, vecs[i].exp_pulses,
                        0, 1, -1, 8'd0, got);
      end

      // Power dropped mid-integration at k=10
      emu_if.count_target = 8'd65;
      emu_if.pulse_div    = 4'd0;
      model_entry(8'd65, t);
      emu_if.RESET_1V8 = 1'b0;
      tick();
      repeat (10) tick();
      emu_if.PWRUP_1V8 = 1'b0;
      tick();
      check("abort_do", int'(emu_if.DO_1V8), 0);
      check("abort_pulse", int'(emu_if.PULSE_1V8), 0);
      check("abort_busy", int'(emu_if.busy), 0);
      check("abort_conv", int'(emu_if.conversions), int'(exp_conv));
      power_up();

      // Early RESET at k=10
      model_entry(8'd65, t);
      emu_if.RESET_1V8 = 1'b0;
      tick();
      repeat (10) tick();
      emu_if.RESET_1V8 = 1'b1;
      tick();
      check("early_busy", int'(emu_if.busy), 0);
      check("early_do", int'(emu_if.DO_1V8), 0);
      do_seen = 0;
      repeat (80) begin
         tick();
         if (emu_if.DO_1V8) do_seen++;
      end
      check("early_no_do", do_seen, 0);
      check("early_conv", int'(emu_if.conversions), int'(exp_conv));

      // Target changed mid-integration is not relatched until next entry
      run_conversion(8'd65, 4'd2, 65, 21, 2, 0, 20, 8'd30, got);
      run_conversion(8'd30, 4'd2, 30, 10, 0, 0, -1, 8'd0, got);

      // Randomized conversions
      for (int i = 0; i < 40; i++) begin
         rct  = 8'($urandom_range(0, 120));
         rpd  = 4'($urandom_range(0, 15));
         rexp = (rct == 8'd0) ? 1 : int'(rct);
         run_conversion(rct, rpd, rexp, rexp / (int'(rpd) + 1),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                        -1, 8'd0, got);
      end

      // 256 one-cycle conversions wrap the counter back to 0
      do_reset();
      for (int i = 0; i < 256; i++) begin
         run_conversion(8'd0, 4'd0, 1, 1, 0, 0, -1, 8'd0, got);
      end
      check("wrap_conv", int'(emu_if.conversions), 0);

`ifdef GREX_EMU_NOISE_EN
      do_reset();
      for (int i = 0; i < 64; i++) begin
         run_conversion(8'd1, 4'd0, 1, 1, 0, 0, -1, 8'd0, got);
         check("noise_range", int'(got == 1 || got == 2), 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
